scmp_busif: RTL

External bus interface for the SC/MP core. It sits between the core's internal memory request and the SC/MP-style system bus. It turns a held request into one arbitrated bus cycle:
- bus request/grant,
- address strobe with the upper address nibble and status flags on the data bus,
- read or write strobe stretched by a wait counter and the HOLD input,
- acknowledge back to the core.

---
 rtl/scmp_bus_pkg.sv | 40 ++++
 rtl/scmp_busif_waitcnt.sv | 36 +++
 rtl/scmp_busif.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/scmp_bus_pkg.sv
// Shared types and constants for the SC/MP external bus interface.
// Imported by the bus FSM and its wait counter.
package scmp_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        ADDR,
        STRB,
        END
    } state_e;

    localparam int DB_R       = 4;
    localparam int DB_I       = 5;
    localparam int STROBE_MIN = 1;
    localparam int STROBE_MAX = 15;

    // Counter preload: the strobe lasts preload+1 cycles.
    function automatic logic [3:0] strobe_preload(input int cycles);
        int c;
        c = cycles;
        if (c < STROBE_MIN) c = STROBE_MIN;
        if (c > STROBE_MAX) c = STROBE_MAX;
        return 4'(c - 1);
    endfunction

    function automatic logic [7:0] status_byte(
        input logic [3:0] addr_hi,
        input logic       we,
        input logic       ifetch
    );
        logic [7:0] b;
        b        = 8'h00;
        b[3:0]   = addr_hi;
        b[DB_R]  = ~we;
        b[DB_I]  = ifetch;
        return b;
    endfunction

endpackage

// File: rtl/scmp_busif_waitcnt.sv
// Loadable 4-bit down-counter timing the read/write strobe width.
// Load has priority; decrement saturates at zero.
import scmp_bus_pkg::*;

module scmp_busif_waitcnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       dec_i,
    output logic       zero_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/scmp_busif.sv
// SC/MP system bus master: arbitrates, strobes address/status, then
// runs one stretched read or write strobe and acknowledges the core.
import scmp_bus_pkg::*;

module scmp_busif #(
    parameter int STROBE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic        cpu_ifetch,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic        bus_breq_n,
    input  logic        bus_enin,
    output logic        bus_enout,
    input  logic        bus_hold,
    output logic [11:0] bus_ad,
    output logic [7:0]  bus_db_o,
    output logic        bus_db_oe,
    input  logic [7:0]  bus_db_i,
    output logic        bus_ads_n,
    output logic        bus_rd_n,
    output logic        bus_wr_n
);

    localparam logic [3:0] PRELOAD = strobe_preload(STROBE_CYCLES);

    state_e      state_q, state_d;
    logic        breq_n_q, breq_n_d;
    logic        ads_n_q, ads_n_d;
    logic        rd_n_q, rd_n_d;
    logic        wr_n_q, wr_n_d;
    logic        db_oe_q, db_oe_d;
    logic [11:0] ad_q, ad_d;
    logic [7:0]  db_o_q, db_o_d;
    logic        ack_q, ack_d;
    logic [7:0]  rdata_q, rdata_d;

    logic        cnt_load;
    logic        cnt_dec;
    logic        cnt_zero;

    assign cnt_load = (state_q == ADDR);
    assign cnt_dec  = (state_q == STRB);

    scmp_busif_waitcnt u_waitcnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (PRELOAD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Outputs are computed for the state being entered, then registered.
    always_comb begin
        state_d  = state_q;
        ad_d     = ad_q;
        db_o_d   = db_o_q;
        rdata_d  = rdata_q;
        breq_n_d = 1'b1;
        ads_n_d  = 1'b1;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        db_oe_d  = 1'b0;
        ack_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    state_d  = ARB;
                    breq_n_d = 1'b0;
                end
            end
            ARB: begin
                breq_n_d = 1'b0;
                if (bus_enin) begin
                    state_d = ADDR;
                    ads_n_d = 1'b0;
                    ad_d    = cpu_addr[11:0];
                    db_oe_d = 1'b1;
                    db_o_d  = status_byte(cpu_addr[15:12], cpu_we,
                                          cpu_ifetch);
                end
            end
            ADDR: begin
                state_d  = STRB;
                breq_n_d = 1'b0;
                rd_n_d   = cpu_we;
                wr_n_d   = ~cpu_we;
                db_oe_d  = cpu_we;
                if (cpu_we) begin
                    db_o_d = cpu_wdata;
                end
            end
            STRB: begin
                db_oe_d = db_oe_q;
                if (cnt_zero && !bus_hold) begin
                    state_d = END;
                    ack_d   = 1'b1;
                    if (!rd_n_q) begin
                        rdata_d = bus_db_i;
                    end
                end else begin
                    breq_n_d = 1'b0;
                    rd_n_d   = rd_n_q;
                    wr_n_d   = wr_n_q;
                end
            end
            END: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            breq_n_q <= 1'b1;
            ads_n_q  <= 1'b1;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            db_oe_q  <= 1'b0;
            ad_q     <= 12'h000;
            db_o_q   <= 8'h00;
            ack_q    <= 1'b0;
            rdata_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            breq_n_q <= breq_n_d;
            ads_n_q  <= ads_n_d;
            rd_n_q   <= rd_n_d;
            wr_n_q   <= wr_n_d;
            db_oe_q  <= db_oe_d;
            ad_q     <= ad_d;
            db_o_q   <= db_o_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus_enout  = bus_enin & (state_q == IDLE) & ~cpu_req;
    assign bus_breq_n = breq_n_q;
    assign bus_ads_n  = ads_n_q;
    assign bus_rd_n   = rd_n_q;
    assign bus_wr_n   = wr_n_q;
    assign bus_db_oe  = db_oe_q;
    assign bus_ad     = ad_q;
    assign bus_db_o   = db_o_q;
    assign cpu_ack    = ack_q;
    assign cpu_rdata  = rdata_q;

endmodule
